// File: rtl/regdst_pkg.sv
// Shared definitions for the register-destination select pipe.
// Holds default sizes, the buffer state encoding and a select-width helper.
package regdst_pkg;

    localparam int DEF_WIDTH = 5;
    localparam int DEF_NSRC  = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    // Select width is clog2 of the source count, never below one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regdst_mux.sv
// Combinational source selector for the register-destination pipe.
// Out-of-range selects yield zero and raise out_of_range_o.
module regdst_mux
    import regdst_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NSRC  = DEF_NSRC,
    localparam int SW   = sel_width(NSRC)
) (
    input  logic [SW-1:0]         sel_i,
    input  logic [NSRC*WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]      value_o,
    output logic                  out_of_range_o
);

    // Pick the addressed source; unmatched selects leave the zero default.
    always_comb begin
        value_o        = '0;
        out_of_range_o = (int'(sel_i) >= NSRC);
        for (int i = 0; i < NSRC; i++) begin
            if (sel_i == SW'(i)) begin
                value_o = data_i[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/regdst_sel_pipe.sv
// Select-and-buffer stage: picks one of NSRC register numbers into a 2-entry skid buffer.
// Optional REGDST_ZERO_SQUASH_EN drops zero-valued pushes (writes to $0).
module regdst_sel_pipe
    import regdst_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NSRC  = DEF_NSRC,
    localparam int SW   = sel_width(NSRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SW-1:0]         in_sel,
    input  logic [NSRC*WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  sel_err
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               in_ready_q;
    logic               sel_err_q, sel_err_d;

    logic [WIDTH-1:0]   sel_val;
    logic               sel_oor;
    logic               push;
    logic               pop;
    logic               store;

    regdst_mux #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC)
    ) u_mux (
        .sel_i          (in_sel),
        .data_i         (in_data),
        .value_o        (sel_val),
        .out_of_range_o (sel_oor)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign sel_err   = sel_err_q;

    assign push = in_valid && in_ready_q && !flush;
    assign pop  = out_valid && out_ready && !flush;

`ifdef REGDST_ZERO_SQUASH_EN
    assign store = push && (sel_val != '0);
`else
    assign store = push;
`endif

    // Next-state of the skid buffer; flush empties it and wins over handshakes.
    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        sel_err_d = sel_err_q | (push & sel_oor);
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (store) begin
                        state_d = ONE;
                        main_d  = sel_val;
                    end
                end
                ONE: begin
                    if (store && pop) begin
                        main_d = sel_val;
                    end else if (store) begin
                        state_d = TWO;
                        skid_d  = sel_val;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Register buffer state, entries, registered ready and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != TWO);
            sel_err_q  <= sel_err_d;
        end
    end

endmodule

// File: tb/tb_regdst_sel_pipe.sv
// Directed self-checking bench for regdst_sel_pipe.
// A second instance with NSRC=3 exercises out-of-range selects.
module tb_regdst_sel_pipe;

    logic        clk;
    logic        rst;

    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [19:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_data;
    logic        sel_err;

    logic        flush3;
    logic        in_valid3;
    logic        in_ready3;
    logic [1:0]  in_sel3;
    logic [14:0] in_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [4:0]  out_data3;
    logic        sel_err3;

    int n_cmp;
    int n_bad;

    regdst_sel_pipe #(.WIDTH(5), .NSRC(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel_err   (sel_err)
    );

    regdst_sel_pipe #(.WIDTH(5), .NSRC(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_sel    (in_sel3),
        .in_data   (in_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
        .sel_err   (sel_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 2'd0;
        in_data    = '0;
        out_ready  = 1'b0;
        flush3     = 1'b0;
        in_valid3  = 1'b0;
        in_sel3    = 2'd0;
        in_data3   = '0;
        out_ready3 = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_sel_err", 32'(sel_err), 0);

        // Single push, sel=1 of {31,7,3,9}
        in_data   = {5'd31, 5'd7, 5'd3, 5'd9};
        in_sel    = 2'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("single_valid", 32'(out_valid), 1);
        check("single_data", 32'(out_data), 3);
        step();
        check("single_drain", 32'(out_valid), 0);

        // Fill both entries with consumer stalled
        out_ready = 1'b0;
        in_sel    = 2'd0;
        in_data   = {5'd31, 5'd7, 5'd3, 5'd5};
        in_valid  = 1'b1;
        step();
        check("fill1_ready", 32'(in_ready), 1);
        in_data = {5'd31, 5'd7, 5'd3, 5'd6};
        step();
        in_valid = 1'b0;
        check("full_ready", 32'(in_ready), 0);
        check("full_head", 32'(out_data), 5);
        step();
        check("stall_hold", 32'(out_data), 5);
        check("stall_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        step();
        check("drain_second", 32'(out_data), 6);
        check("drain_ready", 32'(in_ready), 1);
        step();
        check("drain_empty", 32'(out_valid), 0);

        // Back-to-back stream 1..8
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            in_data = {15'd0, 5'(v)};
            step();
            check("stream_data", 32'(out_data), 32'(v));
            check("stream_ready", 32'(in_ready), 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_end", 32'(out_valid), 0);

        // Flush from TWO beats a simultaneous pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = {15'd0, 5'd10};
        step();
        in_data = {15'd0, 5'd11};
        step();
        in_valid = 1'b0;
        check("pre_flush_ready", 32'(in_ready), 0);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        check("flush_valid", 32'(out_valid), 0);
        check("flush_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = {15'd0, 5'd12};
        step();
        in_valid = 1'b0;
        check("post_flush_data", 32'(out_data), 12);
        step();
        check("post_flush_empty", 32'(out_valid), 0);

        // Zero-valued push followed by 4
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = {15'd0, 5'd0};
        step();
`ifdef REGDST_ZERO_SQUASH_EN
        check("zero_squashed", 32'(out_valid), 0);
`else
        check("zero_valid", 32'(out_valid), 1);
        check("zero_data", 32'(out_data), 0);
`endif
        in_data = {15'd0, 5'd4};
        step();
        in_valid = 1'b0;
        check("four_valid", 32'(out_valid), 1);
        check("four_data", 32'(out_data), 4);
        step();
        check("four_drain", 32'(out_valid), 0);

        // Reset dominates a push in the same cycle
        in_valid = 1'b1;
        in_data  = {15'd0, 5'd9};
        rst      = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_dom_valid", 32'(out_valid), 0);
        check("rst_dom_ready", 32'(in_ready), 1);

        // NSRC=3: in-range then out-of-range select
        in_data3   = {5'd7, 5'd3, 5'd9};
        in_sel3    = 2'd2;
        in_valid3  = 1'b1;
        out_ready3 = 1'b1;
        step();
        check("n3_sel2_data", 32'(out_data3), 7);
        check("n3_sel2_err", 32'(sel_err3), 0);
        in_sel3 = 2'd3;
        step();
        in_valid3 = 1'b0;
`ifdef REGDST_ZERO_SQUASH_EN
        check("n3_oor_squashed", 32'(out_valid3), 0);
`else
        check("n3_oor_valid", 32'(out_valid3), 1);
        check("n3_oor_data", 32'(out_data3), 0);
`endif
        check("n3_oor_err", 32'(sel_err3), 1);
        step();
        check("n3_err_sticky", 32'(sel_err3), 1);
        flush3 = 1'b1;
        step();
        flush3 = 1'b0;
        check("n3_err_after_flush", 32'(sel_err3), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("n3_err_rst", 32'(sel_err3), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
